// File: rtl/systolic_pkg.sv
// Shared types and geometry for the 4x4 output-stationary systolic array drain path.
package systolic_pkg;

  localparam int unsigned N_DIM       = 4;
  localparam int unsigned NUM_PE      = N_DIM * N_DIM;
  localparam int unsigned ACCUM_WIDTH = 32;
  localparam int unsigned CNT_W       = 3;

  typedef logic signed [ACCUM_WIDTH-1:0] accum_t;
  typedef logic [3:0] pe_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    STREAM
  } drain_state_t;

endpackage

// File: rtl/drain_sat_clamp.sv
// Combinational signed clamp of an accumulator word to OUT_WIDTH bits, sign-extended back.
module drain_sat_clamp #(
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned OUT_WIDTH   = 16
) (
  input  logic signed [ACCUM_WIDTH-1:0] data,
  output logic signed [ACCUM_WIDTH-1:0] clamped_c,
  output logic                          sat_c
);

  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX =
    {{(ACCUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN =
    {{(ACCUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  always_comb begin
    clamped_c = data;
    sat_c     = 1'b0;
    if (data > SAT_MAX) begin
      clamped_c = SAT_MAX;
      sat_c     = 1'b1;
    end else if (data < SAT_MIN) begin
      clamped_c = SAT_MIN;
      sat_c     = 1'b1;
    end
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures each PE's K-th accumulator update for a tile, then streams all 16 results in raster order.
// Optional output clamping is built when SYSTOLIC_DRAIN_SAT_EN is defined.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned K_DEPTH     = 4,
  parameter int unsigned ACCUM_WIDTH = 32,
  parameter int unsigned OUT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_PE*ACCUM_WIDTH-1:0] result_flat,
  input  logic [NUM_PE-1:0]             valid_flat,
  output logic [ACCUM_WIDTH-1:0]        out_data,
  output logic [1:0]                    out_row,
  output logic [1:0]                    out_col,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          busy,
  output logic                          tile_done,
  output logic                          err
);

  localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(K_DEPTH - 1);
  localparam logic [CNT_W-1:0] K_FULL   = CNT_W'(K_DEPTH);
  localparam pe_idx_t          LAST_IDX = pe_idx_t'(NUM_PE - 1);

  if (K_DEPTH < 1 || K_DEPTH > 7) begin : g_bad_k_depth
    $error("K_DEPTH must be within 1..7");
  end
  if (OUT_WIDTH < 2 || OUT_WIDTH > ACCUM_WIDTH) begin : g_bad_out_width
    $error("OUT_WIDTH must be within 2..ACCUM_WIDTH");
  end

  drain_state_t                   state;
  pe_idx_t                        idx;
  logic [CNT_W-1:0]               cnt      [NUM_PE];
  logic [NUM_PE-1:0]              captured;
  logic signed [ACCUM_WIDTH-1:0]  acc_buf  [NUM_PE];

  logic [NUM_PE-1:0]              cap_hit;
  logic signed [ACCUM_WIDTH-1:0]  buf_nxt  [NUM_PE];
  logic                           all_cap;
  pe_idx_t                        idx_nxt;
  logic signed [ACCUM_WIDTH-1:0]  sel_word;
  logic signed [ACCUM_WIDTH-1:0]  beat_data;
  logic                           beat_sat;

  // Capture decode; sel_word is the next beat to present (beat 0 may be captured this very edge).
  always_comb begin
    cap_hit = '0;
    for (int p = 0; p < int'(NUM_PE); p++) begin
      cap_hit[p] = valid_flat[p] && !captured[p] && (cnt[p] == K_LAST);
      buf_nxt[p] = cap_hit[p] ? result_flat[p*ACCUM_WIDTH +: ACCUM_WIDTH] : acc_buf[p];
    end
    all_cap  = &(captured | cap_hit);
    idx_nxt  = idx + 4'd1;
    sel_word = (state == COLLECT) ? buf_nxt[0] : acc_buf[idx_nxt];
  end

`ifdef SYSTOLIC_DRAIN_SAT_EN
  drain_sat_clamp #(
    .ACCUM_WIDTH(ACCUM_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_clamp (
    .data     (sel_word),
    .clamped_c(beat_data),
    .sat_c    (beat_sat)
  );
`else
  assign beat_data = sel_word;
  assign beat_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      captured  <= '0;
      for (int p = 0; p < int'(NUM_PE); p++) begin
        cnt[p]     <= '0;
        acc_buf[p] <= '0;
      end
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int p = 0; p < int'(NUM_PE); p++) cnt[p] <= '0;
            captured <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= COLLECT;
          end
        end

        COLLECT: begin
          for (int p = 0; p < int'(NUM_PE); p++) begin
            acc_buf[p] <= buf_nxt[p];
            if (valid_flat[p]) begin
              if (captured[p]) begin
                err    <= 1'b1;
                cnt[p] <= K_FULL;
              end else if (cap_hit[p]) begin
                cnt[p]      <= K_FULL;
                captured[p] <= 1'b1;
              end else begin
                cnt[p] <= cnt[p] + CNT_W'(1);
              end
            end
          end
          if (all_cap) begin
            state     <= STREAM;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_row   <= 2'd0;
            out_col   <= 2'd0;
            out_last  <= 1'b0;
            out_sat   <= beat_sat;
          end
        end

        STREAM: begin
          // Results arriving after capture mean the upstream tile overran its reduction length.
          if (|valid_flat) err <= 1'b1;
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_sat   <= 1'b0;
              busy      <= 1'b0;
              tile_done <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              out_data <= beat_data;
              out_row  <= idx_nxt[3:2];
              out_col  <= idx_nxt[1:0];
              out_last <= (idx_nxt == LAST_IDX);
              out_sat  <= beat_sat;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: normal, backpressure, error, reset and clamp tiles.
module tb_systolic_result_drain;

  localparam int K  = 4;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [16*AW-1:0] result_flat = '0;
  logic [15:0]    valid_flat = '0;
  logic           out_ready = 1'b1;
  logic [AW-1:0]  out_data;
  logic [1:0]     out_row;
  logic [1:0]     out_col;
  logic           out_valid;
  logic           out_last;
  logic           out_sat;
  logic           busy;
  logic           tile_done;
  logic           err;

  int checks = 0;
  int errors = 0;

  logic [31:0] fin     [16];
  logic [31:0] exp_out [16];
  logic        exp_sat [16];

  systolic_result_drain #(
    .K_DEPTH    (K),
    .ACCUM_WIDTH(AW),
    .OUT_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .result_flat(result_flat),
    .valid_flat (valid_flat),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_sat    (out_sat),
    .busy       (busy),
    .tile_done  (tile_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_tile(input int off);
    for (int p = 0; p < 16; p++) begin
      fin[p]     = 32'(100 * p + 7 + off);
      exp_out[p] = fin[p];
      exp_sat[p] = 1'b0;
    end
  endtask

  // Start a tile and feed PE(r,c) K pulses at cycles r+c+1 .. r+c+K after start.
  task automatic collect(input bit inj_err, input bit busy_start);
    logic [15:0]    vf;
    logic [16*AW-1:0] rf;
    @(negedge clk);
    start = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      start = busy_start && (t == 5);
      vf = '0;
      rf = '0;
      for (int p = 0; p < 16; p++) begin
        int k;
        k = t - (p / 4 + p % 4);
        if (k >= 1 && k <= K) begin
          vf[p] = 1'b1;
          rf[p*AW +: AW] = (k == K) ? fin[p] : 32'(100 * p + k);
        end
      end
      if (inj_err && t == 7) begin
        vf[5] = 1'b1;
        rf[5*AW +: AW] = 32'h0000_DEAD;
      end
      valid_flat  = vf;
      result_flat = rf;
      if (t == 1) begin
        chk("busy_after_start", 40'(busy), 40'd1);
        chk("err_cleared_by_start", 40'(err), 40'd0);
      end
      if (t == 10) chk("no_valid_before_last_capture", 40'(out_valid), 40'd0);
    end
    @(negedge clk);
    valid_flat = '0;
    start = 1'b0;
    chk("err_after_collect", 40'(err), 40'(inj_err));
  endtask

  // Drain up to stop_after beats; bp selects ready pattern 1,0,0,1.
  task automatic drain(input bit bp, input bit busy_start, input int stop_after);
    int          acc = 0;
    int          cyc = 0;
    logic        hold = 1'b0;
    logic        rdy;
    logic [31:0] pdata = '0;
    logic [5:0]  pmeta = '0;
    logic [3:0]  a4;
    while (acc < stop_after && cyc < 200) begin
      a4 = 4'(acc);
      if (hold) begin
        chk("stall_data_hold", 40'(out_data), 40'(pdata));
        chk("stall_meta_hold", 40'({out_row, out_col, out_last, out_sat}), 40'(pmeta));
      end
      chk("stream_valid", 40'(out_valid), 40'd1);
      chk("beat_data", 40'(out_data), 40'(exp_out[acc]));
      chk("beat_meta", 40'({out_row, out_col, out_last, out_sat}),
          40'({a4, (acc == 15), exp_sat[acc]}));
      rdy       = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      start     = busy_start && (cyc == 3);
      hold      = !rdy;
      pdata     = out_data;
      pmeta     = {out_row, out_col, out_last, out_sat};
      if (rdy) acc++;
      cyc++;
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("beats_accepted", 40'(acc), 40'(stop_after));
  endtask

  task automatic check_done();
    chk("tile_done_pulse", 40'(tile_done), 40'd1);
    chk("valid_low_at_done", 40'(out_valid), 40'd0);
    chk("busy_low_at_done", 40'(busy), 40'd0);
    @(negedge clk);
    chk("tile_done_one_cycle", 40'(tile_done), 40'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 40'(out_valid), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_err", 40'(err), 40'd0);
    chk("rst_tile_done", 40'(tile_done), 40'd0);
    chk("rst_out_data", 40'(out_data), 40'd0);
    chk("rst_meta", 40'({out_row, out_col, out_last, out_sat}), 40'd0);
    rst_n = 1'b1;

    // Normal tile, always ready.
    set_tile(0);
    collect(1'b0, 1'b0);
    drain(1'b0, 1'b0, 16);
    check_done();

    // Backpressure plus start pulses while busy in both phases.
    collect(1'b0, 1'b1);
    drain(1'b1, 1'b1, 16);
    check_done();
    chk("err_after_busy_start", 40'(err), 40'd0);

    // Extra pulse on PE 5 after capture: sticky error, buffer untouched.
    collect(1'b1, 1'b0);
    drain(1'b0, 1'b0, 16);
    check_done();
    chk("err_sticky", 40'(err), 40'd1);

    // Reset in the middle of streaming an erroneous tile.
    set_tile(1000);
    collect(1'b1, 1'b0);
    drain(1'b0, 1'b0, 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 40'(out_valid), 40'd0);
    chk("midrst_busy", 40'(busy), 40'd0);
    chk("midrst_err", 40'(err), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh tile carrying clamp-boundary values.
    set_tile(0);
    fin[0] = 32'h0001_0000;
    fin[1] = 32'hFFFF_0000;
    fin[2] = 32'h0000_1234;
    exp_out[2] = 32'h0000_1234;
`ifdef SYSTOLIC_DRAIN_SAT_EN
    exp_out[0] = 32'h0000_7FFF;
    exp_sat[0] = 1'b1;
    exp_out[1] = 32'hFFFF_8000;
    exp_sat[1] = 1'b1;
`else
    exp_out[0] = 32'h0001_0000;
    exp_out[1] = 32'hFFFF_0000;
`endif
    collect(1'b0, 1'b0);
    drain(1'b0, 1'b0, 16);
    check_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the 4x4 output-stationary systolic array.
- Watches the 16 per-PE result/valid pairs and counts MAC-update pulses per PE.
- Captures each PE's accumulator after its K-th update for the tile.
- Once all 16 are captured, streams them out in raster order over a valid/ready interface toward the writeback/activation stage.

Parameters:
- K_DEPTH, 4, reduction length: number of valid pulses each PE produces per tile (1..7).
- ACCUM_WIDTH, 32, width of each PE accumulator and of out_data.
- OUT_WIDTH, 16, signed clamp width; used only when SYSTOLIC_DRAIN_SAT_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; arms collection of one tile (honoured in IDLE only).
- result_flat  in  16*ACCUM_WIDTH  PE accumulators; PE(r,c) at index p=r*4+c, bits [p*ACCUM_WIDTH +: ACCUM_WIDTH].
- valid_flat  in  16  per-PE result_valid, bit p.
- out_data  out  ACCUM_WIDTH  current result beat.
- out_row  out  2  row of current beat.
- out_col  out  2  column of current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high with the 16th beat (p=15).
- out_sat  out  1  current beat was clamped (0 when feature is off).
- busy  out  1  state != IDLE.
- tile_done  out  1  one-cycle pulse after the last beat is accepted.
- err  out  1  sticky protocol error; cleared by an accepted start.

Behaviour:
- Reset: state=IDLE, all counters/captured flags/buffer=0; out_valid, out_last, out_sat, busy, tile_done, err=0; out_data/out_row/out_col=0.
- States: IDLE, COLLECT, STREAM.
- IDLE:
  - valid_flat ignored.
  - start=1 → clear cnt[0..15], captured[0..15], err; next state COLLECT.
  - The first valid pulse may arrive the cycle after start.
- COLLECT, per PE p each cycle:
  - valid_flat[p]=1 with cnt[p]<K_DEPTH-1 → cnt[p]++.
  - valid_flat[p]=1 with cnt[p]==K_DEPTH-1 → buf[p] <= result_flat[p] (same cycle the valid is sampled); captured[p] <= 1; cnt[p] <= K_DEPTH.
  - valid_flat[p]=1 with captured[p]=1 → err <= 1; buf[p] unchanged; cnt saturates at K_DEPTH.
- COLLECT exit: if the edge that completes the last capture leaves all 16 captured, move to STREAM on that same edge. First out_valid is high the cycle after the final valid pulse.
- STREAM:
  - out_valid=1 with idx from 0..15; out_data from buf[idx]; out_row=idx[3:2]; out_col=idx[1:0]; out_last=(idx==15).
  - Beat accepted when out_valid && out_ready; idx++.
  - While out_ready=0, all out_* hold stable.
  - Last beat accepted → IDLE; tile_done=1 for the following cycle only; out_valid=0 that cycle.
- start while busy=1 is ignored; no error is raised.
- valid pulses in STREAM set err; buffer is unaffected.
- Reset mid-operation returns everything to reset values immediately; partial tile is discarded.
- Back-to-back tiles: start is accepted in the tile_done cycle (state is IDLE).
- Arithmetic: out_data is a passthrough of the signed accumulator unless the optional feature is enabled; no other arithmetic.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_SAT_EN.
- Defined: each beat is signed-clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sign-extended to ACCUM_WIDTH on out_data. out_sat=1 when clamping occurred. Clamp is combinational on the buffer output; latency unchanged.
- Not defined: out_data = buf[idx] unchanged; out_sat tied 0.

Decomposition:
- Package systolic_pkg:
  - N_DIM=4, NUM_PE=16, ACCUM_WIDTH default.
  - typedef accum_t (logic signed [ACCUM_WIDTH-1:0]).
  - typedef pe_idx_t (logic [3:0]).
  - enum drain_state_t {IDLE, COLLECT, STREAM}.
- Sub-module drain_sat_clamp: combinational signed clamp with ACCUM_WIDTH/OUT_WIDTH parameters. Instantiated only under SYSTOLIC_DRAIN_SAT_EN.

Test Plan:
- Normal tile, out_ready=1:
  - Stimulus: start; PE(r,c) gets 4 valid pulses at cycles r+c+1..r+c+4 with final value 100*p+7.
  - Response: 16 beats 7,107,...,1507 in raster order with correct row/col; out_last on beat 16; tile_done next cycle; busy falls then.
- Backpressure:
  - Stimulus: same tile with out_ready pattern 1,0,0,1 repeating.
  - Response: data/row/col stable during stalls; exactly 16 accepted beats; order identical to the normal tile.
- Protocol error:
  - Stimulus: a 5th valid pulse on PE 5 with result 0xDEAD.
  - Response: err=1 sticky; beat 5 still 507. Next start clears err to 0.
- Reset mid-stream:
  - Stimulus: rst_n low after 7 accepted beats.
  - Response: out_valid/busy/err=0 immediately. A fresh tile then streams all 16 beats correctly.
- Saturation (macro on):
  - Stimulus: results 0x0001_0000 and 0xFFFF_0000.
  - Response: out_data 0x0000_7FFF and 0xFFFF_8000 with out_sat=1; value 0x0000_1234 passes with out_sat=0. Macro off: all three pass through unchanged, out_sat=0.
- start while busy:
  - Stimulus: start pulsed in COLLECT and in STREAM.
  - Response: no effect on counters, buffer or stream; err stays 0.
